// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency unified memory between the IF
//   stage (fetch, read-only) and the MEM stage (load/store).
//
//   Each access is granted in IDLE and then run through BUSY:
//   - memEn is strobed in the first BUSY cycle.
//   - The result is captured when the latency counter reaches MEM_LATENCY.
//   - The owner's Done pulses for one cycle in the following (IDLE) cycle.
//   That Done cycle is also the next arbitration cycle.
//
//   Arbitration:
//   - MEM is preferred.
//   - A starvation counter forces an IF grant once STARVE_LIMIT MEM grants
//     have been made while IF was waiting.
//
//   Optional build macro: ARB_PERF_CNT_EN adds saturating 32-bit stall-cycle
//   counters IFStallCnt / MEMStallCnt.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   IFReq/IFAddr                fetch request (held until IFDone)
//   IFData/IFDone/IFStall       fetch result, done pulse, stall
//   MEMReq/MEMWrite/MEMAddr/MEMWData   load/store request (held until MEMDone)
//   MEMRData/MEMDone/MEMStall   load result, done pulse, stall
//   memEn/memWe/memAddr/memWData/memRData   memory side
//   IFStallCnt/MEMStallCnt      (ARB_PERF_CNT_EN only) stall-cycle counters
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IFReq,
   input  logic [ADDR_W-1:0] IFAddr,
   output logic [DATA_W-1:0] IFData,
   output logic              IFDone,
   output logic              IFStall,
   input  logic              MEMReq,
   input  logic              MEMWrite,
   input  logic [ADDR_W-1:0] MEMAddr,
   input  logic [DATA_W-1:0] MEMWData,
   output logic [DATA_W-1:0] MEMRData,
   output logic              MEMDone,
   output logic              MEMStall,
   output logic              memEn,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       IFStallCnt,
   output logic [31:0]       MEMStallCnt
`endif
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [3:0] LAT = 4'(MEM_LATENCY);
   localparam logic [3:0] SL  = 4'(STARVE_LIMIT);

   logic [0:0]        state;
   logic [3:0]        lat_cnt;
   logic [3:0]        starve_cnt;
   logic              owner_mem;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_data_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              if_done_q;
   logic              mem_done_q;

   logic              if_vld, mem_vld;
   logic              grant_mem, grant_if;
   logic              lat_done;

   // A request whose Done is showing this cycle is the one just served.
   assign if_vld  = IFReq  & ~if_done_q;
   assign mem_vld = MEMReq & ~mem_done_q;

   // MEM wins unless IF has been passed over STARVE_LIMIT times.
   assign grant_mem = (state == IDLE) && mem_vld && ((starve_cnt < SL) || !if_vld);
   assign grant_if  = (state == IDLE) && if_vld && !grant_mem;
   assign lat_done  = (state == BUSY) && (lat_cnt == LAT);

   assign memEn    = (state == BUSY) && (lat_cnt == 4'd1);
   assign memWe    = memEn & owner_mem & we_q;
   assign memAddr  = addr_q;
   assign memWData = wdata_q;

   assign IFData   = if_data_q;
   assign IFDone   = if_done_q;
   assign MEMRData = mem_data_q;
   assign MEMDone  = mem_done_q;
   assign IFStall  = IFReq  & ~if_done_q;
   assign MEMStall = MEMReq & ~mem_done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         owner_mem  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_data_q  <= '0;
         mem_data_q <= '0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_mem) begin
                  state     <= BUSY;
                  lat_cnt   <= 4'd1;
                  owner_mem <= 1'b1;
                  addr_q    <= MEMAddr;
                  wdata_q   <= MEMWData;
                  we_q      <= MEMWrite;
               end else if (grant_if) begin
                  // IF has no write data; memWData keeps its last value
                  state     <= BUSY;
                  lat_cnt   <= 4'd1;
                  owner_mem <= 1'b0;
                  addr_q    <= IFAddr;
                  we_q      <= 1'b0;
               end
            end
            BUSY: begin
               if (lat_done) begin
                  state   <= IDLE;
                  lat_cnt <= '0;
                  if (owner_mem) begin
                     mem_done_q <= 1'b1;
                     // stores leave the previous load data visible
                     if (!we_q) mem_data_q <= memRData;
                  end else begin
                     if_done_q <= 1'b1;
                     if_data_q <= memRData;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Counts MEM grants made while IF was waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         starve_cnt <= '0;
      else if (grant_if || ((state == IDLE) && !IFReq))
         starve_cnt <= '0;
      else if (grant_mem && if_vld && (starve_cnt != SL))
         starve_cnt <= starve_cnt + 4'd1;
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] if_stall_cnt, mem_stall_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_stall_cnt  <= '0;
         mem_stall_cnt <= '0;
      end else begin
         if (IFStall && (if_stall_cnt != 32'hFFFF_FFFF))
            if_stall_cnt <= if_stall_cnt + 32'd1;
         if (MEMStall && (mem_stall_cnt != 32'hFFFF_FFFF))
            mem_stall_cnt <= mem_stall_cnt + 32'd1;
      end
   end

   assign IFStallCnt  = if_stall_cnt;
   assign MEMStallCnt = mem_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
// Inputs are driven just after the falling edge and outputs are checked 1ns later.
// The random test compares against a transaction-timestamp reference model.
module tb_mem_port_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int SL  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          IFReq, MEMReq, MEMWrite;
   logic [AW-1:0] IFAddr, MEMAddr, memAddr;
   logic [DW-1:0] IFData, MEMWData, MEMRData, memWData, memRData;
   logic          IFDone, IFStall, MEMDone, MEMStall, memEn, memWe;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   IFStallCnt, MEMStallCnt;
`endif

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .IFReq(IFReq), .IFAddr(IFAddr), .IFData(IFData), .IFDone(IFDone), .IFStall(IFStall),
      .MEMReq(MEMReq), .MEMWrite(MEMWrite), .MEMAddr(MEMAddr), .MEMWData(MEMWData),
      .MEMRData(MEMRData), .MEMDone(MEMDone), .MEMStall(MEMStall),
      .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData), .memRData(memRData)
`ifdef ARB_PERF_CNT_EN
      , .IFStallCnt(IFStallCnt), .MEMStallCnt(MEMStallCnt)
`endif
   );

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_reset();
      nxt(); reset = 1'b1;
      IFReq = 0; MEMReq = 0; MEMWrite = 0; IFAddr = '0; MEMAddr = '0; MEMWData = '0; memRData = '0;
      nxt(); reset = 1'b0;
   endtask

   task automatic test_reset();
      nxt(); reset = 1'b1;
      IFReq = 0; MEMReq = 0; MEMWrite = 0; IFAddr = '0; MEMAddr = '0; MEMWData = '0; memRData = '0;
      #1;
      vecs++; if (memEn !== 1'b0 || memWe !== 1'b0) begin errs++; $display("FAIL reset_mem got en=%b we=%b exp 0 0", memEn, memWe); end
      vecs++; if (IFDone !== 1'b0 || MEMDone !== 1'b0) begin errs++; $display("FAIL reset_done got if=%b mem=%b exp 0 0", IFDone, MEMDone); end
      vecs++; if (IFData !== '0 || MEMRData !== '0 || memAddr !== '0 || memWData !== '0) begin
         errs++; $display("FAIL reset_regs got ifd=%h memd=%h addr=%h wd=%h exp 0", IFData, MEMRData, memAddr, memWData); end
      nxt(); reset = 1'b0;
   endtask

   task automatic test_single_load();
      nxt(); MEMReq = 1; MEMWrite = 0; MEMAddr = 32'h40; memRData = '0; #1;
      vecs++; if (memEn !== 1'b0 || MEMStall !== 1'b1 || MEMDone !== 1'b0) begin errs++; $display("FAIL load_c0 got en=%b stall=%b done=%b exp 0 1 0", memEn, MEMStall, MEMDone); end
      nxt(); #1;
      vecs++; if (memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h40) begin errs++; $display("FAIL load_c1 got en=%b we=%b addr=%h exp 1 0 40", memEn, memWe, memAddr); end
      MEMAddr = 32'h44; // must be ignored while busy
      nxt(); memRData = 32'hDEADBEEF; #1;
      vecs++; if (memEn !== 1'b0 || MEMStall !== 1'b1 || MEMDone !== 1'b0 || memAddr !== 32'h40) begin
         errs++; $display("FAIL load_c2 got en=%b stall=%b done=%b addr=%h exp 0 1 0 40", memEn, MEMStall, MEMDone, memAddr); end
      nxt(); memRData = '0; #1;
      vecs++; if (MEMDone !== 1'b1 || MEMRData !== 32'hDEADBEEF || MEMStall !== 1'b0) begin
         errs++; $display("FAIL load_c3 got done=%b data=%h stall=%b exp 1 deadbeef 0", MEMDone, MEMRData, MEMStall); end
      nxt(); MEMReq = 0; #1;
      vecs++; if (MEMDone !== 1'b0 || memEn !== 1'b0) begin errs++; $display("FAIL load_c4 got done=%b en=%b exp 0 0", MEMDone, memEn); end
   endtask

   task automatic test_store();
      nxt(); MEMReq = 1; MEMWrite = 1; MEMAddr = 32'h80; MEMWData = 32'h12345678; memRData = 32'hA5A5A5A5; #1;
      vecs++; if (memEn !== 1'b0) begin errs++; $display("FAIL store_c0 got en=%b exp 0", memEn); end
      nxt(); #1;
      vecs++; if (memEn !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h80 || memWData !== 32'h12345678) begin
         errs++; $display("FAIL store_c1 got en=%b we=%b addr=%h wd=%h exp 1 1 80 12345678", memEn, memWe, memAddr, memWData); end
      nxt(); #1;
      vecs++; if (memEn !== 1'b0 || memWe !== 1'b0) begin errs++; $display("FAIL store_c2 got en=%b we=%b exp 0 0", memEn, memWe); end
      nxt(); #1;
      vecs++; if (MEMDone !== 1'b1 || MEMRData !== 32'hDEADBEEF) begin errs++; $display("FAIL store_c3 got done=%b data=%h exp 1 deadbeef", MEMDone, MEMRData); end
      nxt(); MEMReq = 0; MEMWrite = 0; memRData = '0;
   endtask

   task automatic test_conflict();
      nxt(); IFReq = 1; IFAddr = 32'h100; MEMReq = 1; MEMWrite = 0; MEMAddr = 32'h200; memRData = '0; #1;
      vecs++; if (IFStall !== 1'b1 || MEMStall !== 1'b1) begin errs++; $display("FAIL conf_c0 got ifst=%b memst=%b exp 1 1", IFStall, MEMStall); end
      nxt(); #1;
      vecs++; if (memEn !== 1'b1 || memAddr !== 32'h200) begin errs++; $display("FAIL conf_c1 got en=%b addr=%h exp 1 200", memEn, memAddr); end
      nxt(); memRData = 32'h1111; #1;
      nxt(); memRData = '0; #1;
      vecs++; if (MEMDone !== 1'b1 || IFDone !== 1'b0 || IFStall !== 1'b1 || MEMRData !== 32'h1111) begin
         errs++; $display("FAIL conf_c3 got md=%b id=%b ifst=%b data=%h exp 1 0 1 1111", MEMDone, IFDone, IFStall, MEMRData); end
      nxt(); MEMReq = 0; #1;
      vecs++; if (memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h100 || IFStall !== 1'b1) begin
         errs++; $display("FAIL conf_c4 got en=%b we=%b addr=%h ifst=%b exp 1 0 100 1", memEn, memWe, memAddr, IFStall); end
      nxt(); memRData = 32'h2222; #1;
      vecs++; if (IFDone !== 1'b0 || IFStall !== 1'b1) begin errs++; $display("FAIL conf_c5 got id=%b ifst=%b exp 0 1", IFDone, IFStall); end
      nxt(); memRData = '0; #1;
      vecs++; if (IFDone !== 1'b1 || IFData !== 32'h2222 || IFStall !== 1'b0 || MEMRData !== 32'h1111) begin
         errs++; $display("FAIL conf_c6 got id=%b ifd=%h ifst=%b md=%h exp 1 2222 0 1111", IFDone, IFData, IFStall, MEMRData); end
      nxt(); IFReq = 0; #1;
   endtask

   // Both requesters held high: the served requester is ignored in its Done
   // cycle, so grants alternate MEM, IF, MEM, IF every LAT+1 cycles.
   task automatic test_alternation();
      int ifd_at[$];
      int md_at[$];
      nxt(); IFReq = 1; MEMReq = 1; MEMWrite = 0; IFAddr = 32'h500; MEMAddr = 32'h600;
      for (int c = 0; c < 13; c++) begin
         if (c != 0) nxt();
         memRData = 32'(c);
         #1;
         if (IFDone === 1'b1) ifd_at.push_back(c);
         if (MEMDone === 1'b1) md_at.push_back(c);
      end
      vecs++; if (md_at.size() != 2 || md_at[0] != 3 || md_at[1] != 9) begin
         errs++; $display("FAIL alt_memdone got n=%0d first=%0d exp n=2 at 3,9", md_at.size(), (md_at.size() > 0) ? md_at[0] : -1); end
      vecs++; if (ifd_at.size() != 2 || ifd_at[0] != 6 || ifd_at[1] != 12) begin
         errs++; $display("FAIL alt_ifdone got n=%0d first=%0d exp n=2 at 6,12", ifd_at.size(), (ifd_at.size() > 0) ? ifd_at[0] : -1); end
      vecs++; if (IFData !== 32'(11)) begin errs++; $display("FAIL alt_ifdata got %h exp %h", IFData, 32'(11)); end
      nxt(); IFReq = 0; MEMReq = 0;
      do_reset();
   endtask

   task automatic test_reset_mid();
      nxt(); MEMReq = 1; MEMWrite = 0; MEMAddr = 32'h300; memRData = 32'h9999;
      nxt(); #1;
      vecs++; if (memEn !== 1'b1) begin errs++; $display("FAIL rmid_c1 got en=%b exp 1", memEn); end
      nxt(); reset = 1'b1; #1;
      vecs++; if (memEn !== 1'b0 || MEMDone !== 1'b0 || IFDone !== 1'b0) begin
         errs++; $display("FAIL rmid_rst got en=%b md=%b id=%b exp 0 0 0", memEn, MEMDone, IFDone); end
      nxt(); reset = 1'b0; #1;
      vecs++; if (MEMDone !== 1'b0 || memEn !== 1'b0) begin errs++; $display("FAIL rmid_c0 got md=%b en=%b exp 0 0", MEMDone, memEn); end
      nxt(); #1;
      vecs++; if (memEn !== 1'b1 || memAddr !== 32'h300) begin errs++; $display("FAIL rmid_c1b got en=%b addr=%h exp 1 300", memEn, memAddr); end
      nxt(); memRData = 32'h3333; #1;
      vecs++; if (MEMDone !== 1'b0) begin errs++; $display("FAIL rmid_c2b got md=%b exp 0", MEMDone); end
      nxt(); #1;
      vecs++; if (MEMDone !== 1'b1 || MEMRData !== 32'h3333) begin errs++; $display("FAIL rmid_c3b got md=%b data=%h exp 1 3333", MEMDone, MEMRData); end
      nxt(); MEMReq = 0; memRData = '0;
   endtask

   // Reference model: an access granted at cycle g strobes memory at g+1,
   // takes memRData from cycle g+LAT and shows Done at g+LAT+1.
   task automatic test_random();
      bit          busy = 0, own_mem = 0, wflag = 0, ifdn = 0, mdn = 0, nifdn, nmdn, ifv, mv, en;
      int          g = 0, starve = 0;
      logic [31:0] addr = '0, wd = '0, ifd = '0, md = '0;
      longint      pif = 0, pmem = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         nxt();
         if (IFReq && !ifdn) begin
            if ($urandom_range(0, 3) == 0) IFAddr = $urandom;
         end else begin
            IFReq = 1'($urandom_range(0, 1)); IFAddr = $urandom;
         end
         if (MEMReq && !mdn) begin
            if ($urandom_range(0, 3) == 0) begin MEMAddr = $urandom; MEMWData = $urandom; end
         end else begin
            MEMReq = 1'($urandom_range(0, 1)); MEMAddr = $urandom; MEMWData = $urandom;
            MEMWrite = 1'($urandom_range(0, 1));
         end
         memRData = $urandom;
         #1;
         en = busy && (c == g + 1);
         vecs++; if (memEn !== en || memWe !== (en && own_mem && wflag)) begin
            errs++; $display("FAIL rnd_mem c=%0d got en=%b we=%b exp %b %b", c, memEn, memWe, en, en && own_mem && wflag); end
         vecs++; if (memAddr !== addr || (memWe && memWData !== wd)) begin
            errs++; $display("FAIL rnd_addr c=%0d got addr=%h wd=%h exp %h %h", c, memAddr, memWData, addr, wd); end
         vecs++; if (IFDone !== ifdn || MEMDone !== mdn) begin
            errs++; $display("FAIL rnd_done c=%0d got id=%b md=%b exp %b %b", c, IFDone, MEMDone, ifdn, mdn); end
         vecs++; if (IFData !== ifd || MEMRData !== md) begin
            errs++; $display("FAIL rnd_data c=%0d got ifd=%h md=%h exp %h %h", c, IFData, MEMRData, ifd, md); end
         vecs++; if (IFStall !== (IFReq && !ifdn) || MEMStall !== (MEMReq && !mdn)) begin
            errs++; $display("FAIL rnd_stall c=%0d got if=%b mem=%b exp %b %b", c, IFStall, MEMStall, IFReq && !ifdn, MEMReq && !mdn); end
`ifdef ARB_PERF_CNT_EN
         vecs++; if (IFStallCnt !== 32'(pif) || MEMStallCnt !== 32'(pmem)) begin
            errs++; $display("FAIL rnd_perf c=%0d got %0d %0d exp %0d %0d", c, IFStallCnt, MEMStallCnt, pif, pmem); end
`endif
         if (IFReq && !ifdn) pif++;
         if (MEMReq && !mdn) pmem++;
         nifdn = 0; nmdn = 0;
         if (busy) begin
            if (c == g + LAT) begin
               busy = 0;
               if (own_mem) begin nmdn = 1; if (!wflag) md = memRData; end
               else begin nifdn = 1; ifd = memRData; end
            end
         end else begin
            ifv = IFReq && !ifdn;
            mv  = MEMReq && !mdn;
            if (mv && (starve < SL || !ifv)) begin
               busy = 1; own_mem = 1; g = c; addr = MEMAddr; wd = MEMWData; wflag = MEMWrite;
               if (ifv && starve < SL) starve++;
            end else if (ifv) begin
               busy = 1; own_mem = 0; g = c; addr = IFAddr; wflag = 0; starve = 0;
            end
            if (!IFReq) starve = 0;
         end
         ifdn = nifdn; mdn = nmdn;
      end
      nxt(); IFReq = 0; MEMReq = 0;
      do_reset();
   endtask

`ifdef ARB_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      test_conflict();
      vecs++; if (IFStallCnt !== 32'd6 || MEMStallCnt !== 32'd3) begin
         errs++; $display("FAIL perf_conflict got if=%0d mem=%0d exp 6 3", IFStallCnt, MEMStallCnt); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      IFReq = 0; MEMReq = 0; MEMWrite = 0; IFAddr = '0; MEMAddr = '0; MEMWData = '0; memRData = '0;
      test_reset();
      test_single_load();
      test_store();
      test_conflict();
      test_alternation();
      test_reset_mid();
      test_random();
`ifdef ARB_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
